// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode legality helper for the ALU arbiter.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for the opcodes the ALU implements.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters, the arbiter and the result consumer.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_pkg::*;

    logic                 r0_valid;
    logic                 r0_ready;
    logic [WIDTH-1:0]     r0_in1;
    logic [WIDTH-1:0]     r0_in2;
    logic [OP_W-1:0]      r0_op;
    logic                 r0_invalid;

    logic                 r1_valid;
    logic                 r1_ready;
    logic [WIDTH-1:0]     r1_in1;
    logic [WIDTH-1:0]     r1_in2;
    logic [OP_W-1:0]      r1_op;
    logic                 r1_invalid;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [2*WIDTH-1:0]   rsp_out;
    logic                 rsp_zero;
    logic                 rsp_error;

    logic [7:0]           err_cnt0;
    logic [7:0]           err_cnt1;
    logic                 busy;

    modport master (
        output r0_valid, r0_in1, r0_in2, r0_op, r0_invalid,
        output r1_valid, r1_in1, r1_in2, r1_op, r1_invalid,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_error,
        input  err_cnt0, err_cnt1, busy
    );

    modport slave (
        input  r0_valid, r0_in1, r0_in2, r0_op, r0_invalid,
        input  r1_valid, r1_in1, r1_in2, r1_op, r1_invalid,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_error,
        output err_cnt0, err_cnt1, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: add/sub/mul/div on zero-extended operands, double-width result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [OP_W-1:0]    op,
    input  logic               invalid,
    output logic [2*WIDTH-1:0] out,
    output logic               zero,
    output logic               error
);

    localparam int unsigned RW = 2 * WIDTH;

    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [RW-1:0] result;
    logic          div_zero;

    assign a = RW'(in1);
    assign b = RW'(in2);

    // Compute the raw result; an error forces the result to zero and clears the zero flag.
    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV: begin
                if (in2 == '0) div_zero = 1'b1;
                else           result   = a / b;
            end
            default: result = '0;
        endcase
        error = invalid | div_zero;
        out   = error ? '0 : result;
        zero  = !error && (out == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a held response and error counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_arbiter_if.slave bus
);

    localparam int unsigned RW = 2 * WIDTH;

    state_t            state;
    state_t            state_next;
    logic              grant0;
    logic              grant1;
    logic              last_grant;

    logic [WIDTH-1:0]  op_in1;
    logic [WIDTH-1:0]  op_in2;
    logic [OP_W-1:0]   op_code;
    logic              op_inv;
    logic              op_id;

    logic [RW-1:0]     alu_out;
    logic              alu_zero;
    logic              alu_error;

    logic              rsp_valid;
    logic              rsp_id;
    logic [RW-1:0]     rsp_out;
    logic              rsp_zero;
    logic              rsp_error;
    logic [7:0]        err_cnt0;
    logic [7:0]        err_cnt1;
    logic              busy;
    logic              rsp_fire;

    assign rsp_fire = rsp_valid && bus.rsp_ready;

    alu #(.WIDTH(WIDTH)) u_alu (
        .in1     (op_in1),
        .in2     (op_in2),
        .op      (op_code),
        .invalid (op_inv),
        .out     (alu_out),
        .zero    (alu_zero),
        .error   (alu_error)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and round-robin grant; a tie goes to the requester not granted last.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.r0_valid && (!bus.r1_valid || last_grant)) grant0 = 1'b1;
                else if (bus.r1_valid)                             grant1 = 1'b1;
                if (grant0 || grant1) state_next = EXEC;
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, response registers, error counters and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            op_in1     <= '0;
            op_in2     <= '0;
            op_code    <= '0;
            op_inv     <= 1'b0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_out    <= '0;
            rsp_zero   <= 1'b0;
            rsp_error  <= 1'b0;
            err_cnt0   <= 8'd0;
            err_cnt1   <= 8'd0;
            busy       <= 1'b0;
        end else begin
            if (grant0) begin
                op_in1  <= bus.r0_in1;
                op_in2  <= bus.r0_in2;
                op_code <= bus.r0_op;
                op_inv  <= bus.r0_invalid;
                op_id   <= 1'b0;
                last_grant <= 1'b0;
            end else if (grant1) begin
                op_in1  <= bus.r1_in1;
                op_in2  <= bus.r1_in2;
                op_code <= bus.r1_op;
                op_inv  <= bus.r1_invalid;
                op_id   <= 1'b1;
                last_grant <= 1'b1;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_out   <= op_legal(op_code) ? alu_out   : '0;
                rsp_zero  <= op_legal(op_code) ? alu_zero  : 1'b0;
                rsp_error <= op_legal(op_code) ? alu_error : 1'b1;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
                if (rsp_error) begin
                    if (rsp_id) begin
                        if (err_cnt1 != 8'hFF) err_cnt1 <= err_cnt1 + 8'd1;
                    end else begin
                        if (err_cnt0 != 8'hFF) err_cnt0 <= err_cnt0 + 8'd1;
                    end
                end
            end
            busy <= (state_next != IDLE);
        end
    end

    assign bus.r0_ready  = grant0;
    assign bus.r1_ready  = grant1;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_out   = rsp_out;
    assign bus.rsp_zero  = rsp_zero;
    assign bus.rsp_error = rsp_error;
    assign bus.err_cnt0  = err_cnt0;
    assign bus.err_cnt1  = err_cnt1;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: monitor pushes expected results on accept and checks on response.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [15:0] out;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
    alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic id_log[$];
    exp_t rsp_log[$];

    int          m_stage = 0;
    logic        m_last  = 1'b1;
    int          m_cnt0  = 0;
    int          m_cnt1  = 0;
    logic        held    = 1'b0;
    logic [15:0] held_out;
    logic        held_zero, held_err, held_id;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference result from the opcode rules, using plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int op, input bit inv);
        exp_t e;
        int   r;
        e = '0;
        if (!(op inside {0, 1, 2, 4}) || inv || (op == 4 && b == 0)) begin
            e.err = 1'b1;
            return e;
        end
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            default: r = a / b;
        endcase
        e.out  = 16'(r & 32'hFFFF);
        e.zero = (e.out == 16'd0);
        return e;
    endfunction

    // Monitor: protocol model (grant, busy, latency), scoreboard push/pop, stability and counters.
    always @(negedge clk) begin : mon
        logic g0, g1;
        exp_t e;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_stage = 0;
            m_last  = 1'b1;
            m_cnt0  = 0;
            m_cnt1  = 0;
            held    = 1'b0;
        end else begin
            g0 = (m_stage == 0) && bus.r0_valid && (!bus.r1_valid || m_last);
            g1 = (m_stage == 0) && bus.r1_valid && !g0;
            check("r0_ready", 32'(bus.r0_ready), 32'(g0));
            check("r1_ready", 32'(bus.r1_ready), 32'(g1));
            check("busy", 32'(bus.busy), 32'(m_stage != 0));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(m_stage == 2));
            check("err_cnt0", 32'(bus.err_cnt0), 32'(m_cnt0));
            check("err_cnt1", 32'(bus.err_cnt1), 32'(m_cnt1));
            if (held && bus.rsp_valid) begin
                check("hold_out", 32'(bus.rsp_out), 32'(held_out));
                check("hold_flags", 32'({bus.rsp_id, bus.rsp_zero, bus.rsp_error}),
                      32'({held_id, held_zero, held_err}));
            end
            held      = bus.rsp_valid && !bus.rsp_ready;
            held_out  = bus.rsp_out;
            held_zero = bus.rsp_zero;
            held_err  = bus.rsp_error;
            held_id   = bus.rsp_id;
            if (g0) begin
                q0.push_back(model(int'(bus.r0_in1), int'(bus.r0_in2), int'(bus.r0_op), bus.r0_invalid));
                m_last  = 1'b0;
                m_stage = 1;
            end else if (g1) begin
                q1.push_back(model(int'(bus.r1_in1), int'(bus.r1_in2), int'(bus.r1_op), bus.r1_invalid));
                m_last  = 1'b1;
                m_stage = 1;
            end else if (m_stage == 1) begin
                m_stage = 2;
            end else if (m_stage == 2 && bus.rsp_ready) begin
                m_stage = 0;
                if ((bus.rsp_id ? q1.size() : q0.size()) == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = bus.rsp_id ? q1.pop_front() : q0.pop_front();
                    check("rsp_out", 32'(bus.rsp_out), 32'(e.out));
                    check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
                    check("rsp_error", 32'(bus.rsp_error), 32'(e.err));
                    if (e.err) begin
                        if (bus.rsp_id) m_cnt1 = (m_cnt1 == 255) ? 255 : m_cnt1 + 1;
                        else            m_cnt0 = (m_cnt0 == 255) ? 255 : m_cnt0 + 1;
                    end
                end
                id_log.push_back(bus.rsp_id);
                rsp_log.push_back({bus.rsp_out, bus.rsp_zero, bus.rsp_error});
            end
        end
    end

    // Present one operation and hold it until accepted; drop valid after the accepting edge.
    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input bit inv);
        int   n = 0;
        logic ok;
        if (id) begin
            bus.r1_valid = 1'b1; bus.r1_in1 = a; bus.r1_in2 = b; bus.r1_op = op; bus.r1_invalid = inv;
        end else begin
            bus.r0_valid = 1'b1; bus.r0_in1 = a; bus.r0_in2 = b; bus.r0_op = op; bus.r0_invalid = inv;
        end
        forever begin
            @(negedge clk);
            n++;
            ok = id ? bus.r1_ready : bus.r0_ready;
            if (ok || n >= 300) break;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id) bus.r1_valid = 1'b0;
        else    bus.r0_valid = 1'b0;
    endtask

    task automatic rand_stream(input bit id, input int count);
        logic [3:0] ops [10];
        logic [7:0] b;
        ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd15};
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            issue(id, 8'($urandom), b, ops[$urandom_range(0, 9)], $urandom_range(0, 9) == 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_stage != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : main
        logic done;
        exp_t r;
        done = 1'b0;
        bus.r0_valid = 1'b0; bus.r0_in1 = '0; bus.r0_in2 = '0; bus.r0_op = '0; bus.r0_invalid = 1'b0;
        bus.r1_valid = 1'b0; bus.r1_in1 = '0; bus.r1_in2 = '0; bus.r1_op = '0; bus.r1_invalid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_out", 32'(bus.rsp_out), 32'd0);
        check("rst_rsp_flags", 32'({bus.rsp_id, bus.rsp_zero, bus.rsp_error}), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnts", 32'({bus.err_cnt0, bus.err_cnt1}), 32'd0);
        @(posedge clk);
        #1;

        // Single add with two-cycle latency
        issue(1'b0, 8'hAA, 8'h01, 4'd0, 1'b0);
        @(negedge clk);
        check("lat_exec_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_id", 32'(bus.rsp_id), 32'd0);
        check("add_out", 32'(bus.rsp_out), 32'h00AB);
        check("add_flags", 32'({bus.rsp_zero, bus.rsp_error}), 32'd0);
        drain();

        // Tie after reset: r0 first, then r1, next tie back to r0
        do_reset();
        id_log.delete();
        rsp_log.delete();
        fork
            issue(1'b0, 8'h0A, 8'h02, 4'd1, 1'b0);
            issue(1'b1, 8'h04, 8'h02, 4'd2, 1'b0);
        join
        drain();
        check("tie_count", 32'(id_log.size()), 32'd2);
        if (id_log.size() == 2) begin
            check("tie_first", 32'(id_log[0]), 32'd0);
            check("tie_second", 32'(id_log[1]), 32'd1);
            r = rsp_log[0];
            check("tie_out0", 32'(r.out), 32'h0008);
            r = rsp_log[1];
            check("tie_out1", 32'(r.out), 32'h0008);
        end
        id_log.delete();
        fork
            issue(1'b0, 8'h01, 8'h01, 4'd0, 1'b0);
            issue(1'b1, 8'h01, 8'h01, 4'd0, 1'b0);
        join
        drain();
        check("tie_next_r0", 32'(id_log.size() > 0 ? id_log[0] : 1'b1), 32'd0);

        // Error counting and saturation on r1
        do_reset();
        issue(1'b1, 8'h08, 8'h00, 4'd4, 1'b0);
        drain();
        check("div0_cnt1", 32'(bus.err_cnt1), 32'd1);
        issue(1'b1, 8'h05, 8'h03, 4'd0, 1'b1);
        drain();
        check("inv_cnt1", 32'(bus.err_cnt1), 32'd2);
        repeat (260) issue(1'b1, 8'($urandom), 8'($urandom), 4'd0, 1'b1);
        drain();
        check("sat_cnt1", 32'(bus.err_cnt1), 32'hFF);
        check("sat_cnt0", 32'(bus.err_cnt0), 32'd0);

        // Zero flag and illegal opcode bypass
        rsp_log.delete();
        issue(1'b0, 8'h08, 8'h08, 4'd1, 1'b0);
        issue(1'b0, 8'h08, 8'h08, 4'd3, 1'b0);
        drain();
        if (rsp_log.size() == 2) begin
            r = rsp_log[0];
            check("sub_zero", 32'({r.out, r.zero, r.err}), 32'({16'h0000, 1'b1, 1'b0}));
            r = rsp_log[1];
            check("illegal_op", 32'({r.out, r.zero, r.err}), 32'({16'h0000, 1'b0, 1'b1}));
        end else begin
            check("zero_illegal_count", 32'(rsp_log.size()), 32'd2);
        end
        check("illegal_cnt0", 32'(bus.err_cnt0), 32'd1);

        // Back-pressure: response held, nothing granted, r1 granted right after release
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'h03, 8'h04, 4'd2, 1'b0);
        fork
            issue(1'b1, 8'h01, 8'h01, 4'd0, 1'b0);
        join_none
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("bp_readies", 32'({bus.r0_ready, bus.r1_ready}), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
            check("bp_out", 32'(bus.rsp_out), 32'h000C);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_grant_r1", 32'(bus.r1_ready), 32'd1);
        wait fork;
        drain();

        // Reset during EXEC aborts the operation
        do_reset();
        issue(1'b0, 8'h10, 8'h20, 4'd0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_valid", 32'(bus.rsp_valid), 32'd0);
            check("abort_busy", 32'(bus.busy), 32'd0);
            check("abort_cnt0", 32'(bus.err_cnt0), 32'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic from both requesters with random back-pressure
        do_reset();
        fork
            begin
                fork
                    rand_stream(1'b0, 150);
                    rand_stream(1'b1, 150);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width; result width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 r0_valid / r1_valid  input  1  requester 0/1 presents an operation.
REQ-005 r0_ready / r1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 r0_in1, r0_in2 / r1_in1, r1_in2  input  WIDTH  operands.
REQ-007 r0_op / r1_op  input  4  opcode: 0 add, 1 sub, 2 mul, 4 div.
REQ-008 r0_invalid / r1_invalid  input  1  requester marks operands invalid.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_out  output  2*WIDTH  result; rsp_zero output 1 zero flag; rsp_error output 1 error flag.
REQ-013 err_cnt0 / err_cnt1  output  8  saturating error counts per requester.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on handshake, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid&&rsp_ready.
REQ-016 Handshake: a transfer occurs when rX_valid&&rX_ready at a rising edge; rX_ready SHALL be high only in IDLE and only for the granted requester; at most one rX_ready high per cycle.
REQ-017 Arbitration is round-robin: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted; after reset, requester 0 wins the first tie.
REQ-018 rX_ready is combinational from rX_valid, state and the round-robin pointer; rX_valid SHALL not depend on rX_ready.
REQ-019 On handshake, operands, op, invalid and requester id are registered; ALU inputs are driven from these registers throughout EXEC.
REQ-020 In EXEC, ALU out/zero/error are captured into response registers; rsp_valid rises on the next cycle, giving 2 cycles of latency from handshake to rsp_valid.
REQ-021 Opcodes other than 0, 1, 2 and 4 SHALL bypass the ALU result: rsp_out=0, rsp_zero=0, rsp_error=1.
REQ-022 rsp_error is high for ALU error (divide by zero or invalid), so invalid=1 always yields rsp_error=1.
REQ-023 While rsp_valid&&!rsp_ready, rsp_out/zero/error/id are held stable and no new request is accepted.
REQ-024 err_cnt of rsp_id increments by 1 on each response handshake with rsp_error=1; it saturates at 8'hFF and does not wrap.
REQ-025 A pending rX_valid during EXEC or RESP is not lost; it is arbitrated on return to IDLE, and the return to IDLE and the next grant can occur in back-to-back cycles (grant in the first IDLE cycle).

Reset
REQ-026 rst high at a clock edge forces, from the next cycle: state IDLE, r0_ready=r1_ready=0 until the first IDLE evaluation, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0, rsp_error=0, err_cnt0=err_cnt1=0, busy=0, round-robin pointer = requester 1 last granted.
REQ-027 Reset asserted mid-operation (EXEC or RESP) aborts the operation with no response emitted and no counter update.

Structure
REQ-028 Shared package alu_pkg holds: the opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=4; the FSM state enum; and an opcode-legal function.
REQ-029 One sub-module: the existing ALU #(WIDTH), instantiated once inside alu_arbiter; no other hierarchy.

Verification
REQ-030 r0 issues in1=aa, in2=01, op=0 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_out=00ab, zero=0, error=0.
REQ-031 After reset, both requesters are valid at once: r0 (0a,02,op1) and r1 (04,02,op2) -> r0 is served first with rsp_out=0008, then r1 with rsp_out=0008; the next tie goes to r0.
REQ-032 r1 issues 08/00 op=4 -> rsp_error=1 and err_cnt1=1; a second request with invalid=1 -> err_cnt1=2; 260 error responses -> err_cnt1=ff.
REQ-033 r0 issues 08-08 op=1 -> rsp_out=0000, rsp_zero=1, rsp_error=0; r0 op=3 -> rsp_out=0000, rsp_error=1.
REQ-034 rsp_ready is held low for 5 cycles with r1 valid -> response stable, r0_ready=r1_ready=0, busy=1; release -> r1 is granted the next cycle.
REQ-035 rst is pulsed during EXEC -> no rsp_valid, err_cnt unchanged at 0, busy=0 the cycle after reset.
